// File: rtl/flash_ctrl_if.sv
// flash_ctrl_if: request/ack bus between a master (bus master / boot loader)
// and flash_ctrl.
//   req, cmd, addr, wdata         master -> controller (held until ack)
//   ack, rdata, err, err_code     controller -> master (valid with ack)
//   ctrl_busy                     controller -> master (not IDLE or startup guard)
interface flash_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [1:0]        err_code;
    logic              ctrl_busy;

    modport master (
        output req, cmd, addr, wdata,
        input  ack, rdata, err, err_code, ctrl_busy
    );

    modport slave (
        input  req, cmd, addr, wdata,
        output ack, rdata, err, err_code, ctrl_busy
    );
endinterface

// File: rtl/flash_ctrl.sv
// flash_ctrl: request/ack front end for a 1024x32 flash array.
// Takes one NOP/READ/WRITE/ERASE command at a time, range-checks the address,
// issues a single-cycle flash strobe, waits TURNAROUND cycles, then returns
// status with a one-cycle ack.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bus           flash_ctrl_if.slave (req/cmd/addr/wdata in, ack/rdata/err/err_code/ctrl_busy out)
//   fl_rd_en, fl_wr_en, fl_erase_en   single-cycle flash strobes
//   fl_addr, fl_idata                 registered at accept, stable through DONE
//   fl_odata, fl_busy, fl_error       flash read data, busy, one-cycle error pulse
// Configuration macro: FLASH_CTRL_VERIFY_EN adds a read-back verify after
// each WRITE that completed without a flash error (mismatch -> err_code 11).
module flash_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    flash_ctrl_if.slave       bus,
    output logic              fl_rd_en,
    output logic              fl_wr_en,
    output logic              fl_erase_en,
    output logic [ADDR_W-1:0] fl_addr,
    output logic [DATA_W-1:0] fl_idata,
    input  logic [DATA_W-1:0] fl_odata,
    input  logic              fl_busy,
    input  logic              fl_error
);
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_ERASE = 2'b11;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_RANGE  = 2'b01;
    localparam logic [1:0] ERR_FLASH  = 2'b10;
    localparam logic [1:0] ERR_VERIFY = 2'b11;

    localparam int              CNT_W     = $clog2(TURNAROUND + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TURNAROUND - 1);
    localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef FLASH_CTRL_VERIFY_EN
        S_VRD_ISSUE,
        S_VRD_WAIT,
`endif
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        cmd_q;
    logic [1:0]        code_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        guard;
    logic [CNT_W-1:0]  wait_cnt;

    logic accept, range_err, short_path, wait_last, issuing;

    // Flash has no reset and may still be draining an op, so hold off
    // accepts for two cycles after reset release.
    assign accept     = (state == S_IDLE) && bus.req && !fl_busy && (guard == 2'd0);
    assign range_err  = ((bus.cmd == CMD_READ) || (bus.cmd == CMD_WRITE)) &&
                        ({1'b0, bus.addr} >= DEPTH_V);
    assign short_path = (bus.cmd == CMD_NOP) || range_err;
    assign wait_last  = (wait_cnt == '0);

`ifdef FLASH_CTRL_VERIFY_EN
    assign issuing = (state == S_ISSUE) || (state == S_VRD_ISSUE);
`else
    assign issuing = (state == S_ISSUE);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = short_path ? S_DONE : S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
`ifdef FLASH_CTRL_VERIFY_EN
                    // A write that already failed in flash is not verified.
                    if (cmd_q == CMD_WRITE && code_q == ERR_NONE && !fl_error)
                        state_n = S_VRD_ISSUE;
                    else
`endif
                        state_n = S_DONE;
                end
            end
`ifdef FLASH_CTRL_VERIFY_EN
            S_VRD_ISSUE: state_n = S_VRD_WAIT;
            S_VRD_WAIT:  if (wait_last) state_n = S_DONE;
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: strobes and ack decode straight from state so that reset
    // drops them in the same instant.
    always_comb begin
        fl_rd_en     = 1'b0;
        fl_wr_en     = 1'b0;
        fl_erase_en  = 1'b0;
        bus.ack      = 1'b0;
        case (state)
            S_ISSUE: begin
                fl_rd_en    = (cmd_q == CMD_READ);
                fl_wr_en    = (cmd_q == CMD_WRITE);
                fl_erase_en = (cmd_q == CMD_ERASE);
            end
`ifdef FLASH_CTRL_VERIFY_EN
            S_VRD_ISSUE: fl_rd_en = 1'b1;
`endif
            S_DONE:  bus.ack = 1'b1;
            default: ;
        endcase
        bus.err       = (state == S_DONE) && (code_q != ERR_NONE);
        bus.err_code  = (state == S_DONE) ? code_q : ERR_NONE;
        bus.rdata     = rdata_q;
        bus.ctrl_busy = (state != S_IDLE) || (guard != 2'd0);
    end

    // Datapath: command latch, status latch, read data, counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= CMD_NOP;
            code_q   <= ERR_NONE;
            rdata_q  <= '0;
            fl_addr  <= '0;
            fl_idata <= '0;
            guard    <= 2'd2;
            wait_cnt <= '0;
        end else begin
            if (guard != 2'd0) guard <= guard - 2'd1;

            if (accept) begin
                cmd_q    <= bus.cmd;
                fl_addr  <= bus.addr;
                fl_idata <= bus.wdata;
                code_q   <= range_err ? ERR_RANGE : ERR_NONE;
            end

            if (issuing)                wait_cnt <= WAIT_LOAD;
            else if (wait_cnt != '0)    wait_cnt <= wait_cnt - 1'b1;

            if (state == S_WAIT) begin
                // Erase errors are deliberately not reported.
                if (fl_error && cmd_q != CMD_ERASE) code_q <= ERR_FLASH;
                if (wait_last && cmd_q == CMD_READ) rdata_q <= fl_odata;
            end
`ifdef FLASH_CTRL_VERIFY_EN
            if (state == S_VRD_WAIT) begin
                if (fl_error)
                    code_q <= ERR_FLASH;
                else if (wait_last && fl_odata != fl_idata && code_q == ERR_NONE)
                    code_q <= ERR_VERIFY;
            end
`endif
        end
    end
endmodule
